// File: rtl/regfile_pkg.sv
// Shared defaults, types and helpers for the scoreboarded integer register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned POP_W         = 1024;

    typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0]          xlen_t;

    // Counts set bits; callers zero-extend their vector to POP_W.
    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_busy_sb.sv
// Pending-write scoreboard: busy bits, claim accept logic, flush and busy population count.
module regfile_busy_sb
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned AW    = $clog2(NREGS),
    parameter int unsigned CW    = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             claim_en,
    input  logic [AW-1:0]    claim_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic             claim_ok_c,
    output logic [CW-1:0]    pending_count
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    pending_count_q, pending_count_d;

    always_comb begin
        claim_ok_c = claim_en & ~flush &
                     ((claim_addr == '0) | ~busy_q[claim_addr] |
                      (wr_en & (wr_addr == claim_addr)));
    end

    // Later assignments win: flush over claim set over write clear.
    always_comb begin
        busy_d = busy_q;
        if (wr_en && (wr_addr != '0)) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (claim_ok_c && (claim_addr != '0)) begin
            busy_d[claim_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
        pending_count_d = CW'(popcount(POP_W'(busy_d)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q          <= '0;
            pending_count_q <= '0;
        end else begin
            busy_q          <= busy_d;
            pending_count_q <= pending_count_d;
        end
    end

    assign busy          = busy_q;
    assign pending_count = pending_count_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with hardwired x0, optional write bypass and pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned NREGS  = NREGS_DEFAULT,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREAD*$clog2(NREGS)-1:0] rs_addr,
    output logic [NREAD*XLEN-1:0]      rs_data,
    output logic [NREAD-1:0]           rs_busy,
    input  logic                       wr_en,
    input  logic [$clog2(NREGS)-1:0]   wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic                       claim_en,
    input  logic [$clog2(NREGS)-1:0]   claim_addr,
    output logic                       claim_ok,
    input  logic                       flush,
    output logic [$clog2(NREGS+1)-1:0] pending_count
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned CW = $clog2(NREGS + 1);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_live) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_busy_sb #(
        .NREGS (NREGS),
        .AW    (AW),
        .CW    (CW)
    ) u_busy (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .claim_en      (claim_en),
        .claim_addr    (claim_addr),
        .flush         (flush),
        .busy          (busy),
        .claim_ok_c    (claim_ok),
        .pending_count (pending_count)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rd_data;
        logic            rd_busy;

        assign addr = rs_addr[i*AW +: AW];

        // x0 first, then same-cycle forwarding, then stored state.
        always_comb begin
            rd_data = mem_q[addr];
            rd_busy = busy[addr];
            if (addr == '0) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end else if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
                rd_data = wr_data;
                rd_busy = 1'b0;
            end
        end

        assign rs_data[i*XLEN +: XLEN] = rd_data;
        assign rs_busy[i]              = rd_busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: bypassing and non-bypassing instances share one stimulus stream.
module tb_regfile_sb;
    import regfile_pkg::*;

    typedef struct {
        string     name;
        xlen_t     d0;
        xlen_t     d1;
        logic      b0;
        logic      b1;
        logic      ok;
        logic [5:0] pc;
        xlen_t     nb0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data, nb_rs_data;
    logic [1:0]  rs_busy, nb_rs_busy;
    logic        wr_en;
    reg_addr_t   wr_addr;
    xlen_t       wr_data;
    logic        claim_en;
    reg_addr_t   claim_addr;
    logic        claim_ok, nb_claim_ok;
    logic        flush;
    logic [5:0]  pending_count, nb_pending_count;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(claim_ok),
        .flush(flush), .pending_count(pending_count)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(nb_rs_data), .rs_busy(nb_rs_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(nb_claim_ok),
        .flush(flush), .pending_count(nb_pending_count)
    );

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h, want %h", name, field, act, exp);
        end
    endtask

    // Drives one cycle of stimulus at the falling edge and queues what the outputs must show.
    task automatic apply(input string name, input logic r,
                         input reg_addr_t a0, input reg_addr_t a1,
                         input logic we, input reg_addr_t wa, input xlen_t wd,
                         input logic ce, input reg_addr_t ca, input logic fl,
                         input xlen_t d0, input xlen_t d1, input logic b0, input logic b1,
                         input logic ok, input logic [5:0] pc, input xlen_t nb0);
        exp_t e;
        @(negedge clk);
        rst = r; rs_addr = {a1, a0};
        wr_en = we; wr_addr = wa; wr_data = wd;
        claim_en = ce; claim_addr = ca; flush = fl;
        e.name = name; e.d0 = d0; e.d1 = d1; e.b0 = b0; e.b1 = b1;
        e.ok = ok; e.pc = pc; e.nb0 = nb0;
        sb_q.push_back(e);
    endtask

    // Monitor: samples one time unit before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_vec++;
                check(e.name, "rs_data0", rs_data[31:0], e.d0);
                check(e.name, "rs_data1", rs_data[63:32], e.d1);
                check(e.name, "rs_busy0", 32'(rs_busy[0]), 32'(e.b0));
                check(e.name, "rs_busy1", 32'(rs_busy[1]), 32'(e.b1));
                check(e.name, "claim_ok", 32'(claim_ok), 32'(e.ok));
                check(e.name, "pending_count", 32'(pending_count), 32'(e.pc));
                check(e.name, "nb_rs_data0", nb_rs_data[31:0], e.nb0);
                check(e.name, "nb_pending_count", 32'(nb_pending_count), 32'(e.pc));
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1; rs_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        claim_en = 1'b0; claim_addr = '0; flush = 1'b0;

        //          name        rst a0  a1  we wa  wd            ce ca  fl  d0            d1            b0 b1 ok pc nb0
        apply("reset",       1, 0,  5,  0, 0,  0,            0, 0,  0,  0,            0,            0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            apply("read_all", 0, reg_addr_t'(i), reg_addr_t'(31 - i), 0, 0, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0);
        end
        apply("wr_x5_byp",   0, 5,  5,  1, 5,  32'hDEADBEEF, 0, 0,  0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        apply("rd_x5",       0, 5,  0,  0, 0,  0,            0, 0,  0,  32'hDEADBEEF, 0,            0, 0, 0, 0, 32'hDEADBEEF);
        apply("wr_claim_x0", 0, 0,  0,  1, 0,  32'h1234,     1, 0,  0,  0,            0,            0, 0, 1, 0, 0);
        apply("rd_x0",       0, 0,  0,  0, 0,  0,            0, 0,  0,  0,            0,            0, 0, 0, 0, 0);
        apply("claim_x7",    0, 7,  7,  0, 0,  0,            1, 7,  0,  0,            0,            0, 0, 1, 0, 0);
        apply("reclaim_x7",  0, 7,  0,  0, 0,  0,            1, 7,  0,  0,            0,            1, 0, 0, 1, 0);
        apply("wb_x7",       0, 7,  7,  1, 7,  32'h55,       0, 0,  0,  32'h55,       32'h55,       0, 0, 0, 1, 0);
        apply("rd_x7",       0, 7,  0,  0, 0,  0,            0, 0,  0,  32'h55,       0,            0, 0, 0, 0, 32'h55);
        apply("claim_x3",    0, 3,  4,  0, 0,  0,            1, 3,  0,  0,            0,            0, 0, 1, 0, 0);
        apply("claim_x4",    0, 3,  4,  0, 0,  0,            1, 4,  0,  0,            0,            1, 0, 1, 1, 0);
        apply("claim_x9",    0, 3,  4,  0, 0,  0,            1, 9,  0,  0,            0,            1, 1, 1, 2, 0);
        apply("flush_x10",   0, 9,  5,  0, 0,  0,            1, 10, 1,  0,            32'hDEADBEEF, 1, 0, 0, 3, 0);
        apply("post_flush",  0, 9,  10, 0, 0,  0,            0, 0,  0,  0,            0,            0, 0, 0, 0, 0);
        apply("data_kept",   0, 5,  7,  0, 0,  0,            0, 0,  0,  32'hDEADBEEF, 32'h55,       0, 0, 0, 0, 32'hDEADBEEF);
        apply("claim_x12",   0, 12, 0,  0, 0,  0,            1, 12, 0,  0,            0,            0, 0, 1, 0, 0);
        apply("wr_claim_x12",0, 12, 12, 1, 12, 32'hABCD,     1, 12, 0,  32'hABCD,     32'hABCD,     0, 0, 1, 1, 0);
        apply("rd_x12",      0, 12, 0,  0, 0,  0,            0, 0,  0,  32'hABCD,     0,            1, 0, 0, 1, 32'hABCD);
        apply("claim_x20",   0, 12, 20, 0, 0,  0,            1, 20, 0,  32'hABCD,     0,            1, 0, 1, 1, 32'hABCD);
        apply("async_rst",   1, 12, 5,  0, 0,  0,            0, 0,  0,  0,            0,            0, 0, 0, 0, 0);
        apply("post_rst",    0, 12, 20, 0, 0,  0,            0, 0,  0,  0,            0,            0, 0, 0, 0, 0);
        apply("wb_x20",      0, 20, 0,  1, 20, 32'h77,       0, 0,  0,  32'h77,       0,            0, 0, 0, 0, 0);
        apply("rd_x20",      0, 20, 20, 0, 0,  0,            0, 0,  0,  32'h77,       32'h77,       0, 0, 0, 0, 32'h77);

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the monocycle core with a per-register pending-write scoreboard. It adds configurable width, depth and read-port count; a hardwired-zero register 0; optional write-to-read bypass; and busy tracking for long-latency writers such as loads and multi-cycle units. It sits between decode, which reads operands and claims destinations, and writeback, which retires claimed registers.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, register count; must be a power of two and ≥ 2.
- NREAD, 2, number of read ports.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = no forwarding.
- Derived AW = $clog2(NREGS); CW = $clog2(NREGS+1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs_addr  in  NREAD*AW  read addresses; port i uses slice [i*AW +: AW].
- rs_data  out  NREAD*XLEN  read data per port.
- rs_busy  out  NREAD  pending-write flag per read port.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- claim_en  in  1  request to mark claim_addr pending.
- claim_addr  in  AW  destination to claim.
- claim_ok  out  1  claim accepted this cycle (combinational).
- flush  in  1  clear all busy bits.
- pending_count  out  CW  number of busy registers (registered).

## Operation
- Storage: NREGS×XLEN data array plus NREGS busy bits. Register 0 reads 0, is never busy, and ignores writes and claims.
- Read (combinational), per port:
  - addr 0: rs_data = 0, rs_busy = 0.
  - BYPASS=1 and wr_en and wr_addr == rs_addr ≠ 0: rs_data = wr_data, rs_busy = 0.
  - Otherwise: stored value and stored busy bit.
- Write: with wr_en and wr_addr ≠ 0, data[wr_addr] ← wr_data and busy[wr_addr] ← 0 at the edge.
  - A write to a non-busy register is legal and only updates data.
- Claim: claim_ok = claim_en & ~flush & (claim_addr == 0 | ~busy[claim_addr] | (wr_en & wr_addr == claim_addr)).
  - On claim_ok with claim_addr ≠ 0, busy[claim_addr] ← 1.
  - A claim to a busy register is refused (claim_ok = 0); the requester stalls and retries.
- Simultaneous write and claim to the same nonzero address: data is written and the busy bit ends at 1 (the new claim supersedes the retired one).
- Flush: all busy bits ← 0 at the edge. Data array is untouched, a same-cycle write still lands, and claims are refused.
- pending_count: registered population count of the next-state busy vector. It is always equal to the number of set busy bits and never exceeds NREGS−1.

## Timing
- Read latency 0 cycles (combinational from rs_addr and the write port).
- Write and claim take effect at the next rising edge. Without bypass, a read returns the new value in the cycle after the write.
- claim_ok is combinational in the request cycle; no handshake beyond a single-cycle accept/refuse.
- Reset (asynchronous assert, value held while rst = 1):
  - data array all 0, busy all 0, pending_count = 0.
  - Consequently rs_data = 0 and rs_busy = 0 for every port.
- Reset mid-operation discards all pending claims; writeback for those claims after reset only updates data.
- Priority at an edge: rst > flush (for busy) > claim set > write clear.

## Structure
- Package regfile_pkg holds:
  - default XLEN and NREGS
  - typedefs reg_addr_t and xlen_t
  - a popcount function used for pending_count
- Sub-module regfile_busy_sb: busy-bit vector, claim_ok logic, flush and pending_count. The top holds the data array, read muxes and bypass.
- Read ports are generated with a generate loop over NREAD.

## Test plan
- Reset, then read all addresses on both ports → every rs_data = 0, rs_busy = 0, pending_count = 0.
- Write 0xDEADBEEF to x5 and read x5 in the same cycle: with BYPASS=1 → rs_data = 0xDEADBEEF immediately; with BYPASS=0 → old value, then 0xDEADBEEF the next cycle.
- Write 0x1234 to x0 and claim x0 → reads of x0 stay 0, claim_ok = 1, pending_count stays 0.
- Claim x7, then claim x7 again → first claim_ok = 1 with pending_count = 1; second claim_ok = 0. Write x7 = 0x55 → busy cleared, pending_count = 0, read returns 0x55.
- Claim x3, x4, x9 over three cycles, then assert flush together with a claim of x10 → claim_ok = 0, all busy bits 0, pending_count = 0, data unchanged.
- Same-cycle write and claim of x12 while x12 is busy → claim_ok = 1, data updated, busy stays 1, pending_count unchanged. Assert rst mid-sequence → all outputs return to 0 asynchronously.
